// File: rtl/dac_feeder.sv
// Stereo sample scheduler: FIFO of 40-bit L/R pairs feeding a held pair to the I2S DAC.
// Each DAC next pulse loads one FIFO entry into the holding registers, or silence if the FIFO is empty.
module dac_feeder #(
  parameter int DEPTH_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  input  logic [39:0]           wr_data,
  output logic                  wr_ready,
  input  logic                  enable,
  input  logic                  mute,
  input  logic                  flush,
  input  logic [DEPTH_LOG2:0]   thresh,
  input  logic                  next,
  output logic [19:0]           sample_l,
  output logic [19:0]           sample_r,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underrun,
  input  logic                  underrun_clr,
  output logic                  irq
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [39:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [39:0]           head;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  starve;

  // wr_ready comes from the registered level, so a pop cannot free a slot in the same cycle.
  assign wr_ready = (level != FULL);
  assign empty    = (level == '0);
  assign push     = wr_valid & wr_ready & ~flush;
  assign pop      = next & enable & ~empty & ~flush;
  assign starve   = next & enable & empty & ~flush;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Holding registers run one frame ahead: the DAC captures the old pair on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_l <= '0;
      sample_r <= '0;
    end else if (next) begin
      if (pop && !mute) begin
        sample_l <= head[39:20];
        sample_r <= head[19:0];
      end else begin
        sample_l <= '0;
        sample_r <= '0;
      end
    end
  end

  // A starvation event wins over a clear arriving in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun <= 1'b0;
    end else if (starve) begin
      underrun <= 1'b1;
    end else if (underrun_clr) begin
      underrun <= 1'b0;
    end
  end

  assign irq = enable & (level <= thresh);

endmodule

// File: tb/tb_dac_feeder.sv
// Scoreboard bench for dac_feeder: a queue model of the FIFO predicts each held pair.
module tb_dac_feeder;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_valid;
  logic [39:0] wr_data;
  logic        wr_ready;
  logic        enable;
  logic        mute;
  logic        flush;
  logic [5:0]  thresh;
  logic        next;
  logic [19:0] sample_l;
  logic [19:0] sample_r;
  logic [5:0]  level;
  logic        underrun;
  logic        underrun_clr;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic [39:0] mq[$];
  logic [39:0] exp_q[$];
  logic        m_under;

  dac_feeder #(.DEPTH_LOG2(5)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .enable(enable), .mute(mute), .flush(flush), .thresh(thresh), .next(next),
    .sample_l(sample_l), .sample_r(sample_r), .level(level), .underrun(underrun),
    .underrun_clr(underrun_clr), .irq(irq)
  );

  always #5 clk = ~clk;

  // Drive one cycle, update the model, push expected hold values on every next.
  task automatic step(input logic v, input logic [39:0] d, input logic nx, input logic fl);
    int sz;
    logic set;
    logic [39:0] e;
    sz  = mq.size();
    set = 1'b0;
    wr_valid = v; wr_data = d; next = nx; flush = fl;
    if (fl) begin
      mq.delete();
      if (nx) exp_q.push_back(40'd0);
    end else begin
      if (nx) begin
        if (!enable) begin
          exp_q.push_back(40'd0);
        end else if (sz > 0) begin
          e = mq.pop_front();
          exp_q.push_back(mute ? 40'd0 : e);
        end else begin
          exp_q.push_back(40'd0);
          set = 1'b1;
        end
      end
      if (v && sz < DEPTH) mq.push_back(d);
    end
    if (set) m_under = 1'b1;
    else if (underrun_clr) m_under = 1'b0;
    @(posedge clk); #1;
    wr_valid = 1'b0; next = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; thresh = 6'd0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    mq.delete(); exp_q.delete(); m_under = 1'b0;
    n_checks++; if (level !== 6'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", level); end
    n_checks++; if ({sample_l, sample_r} !== 40'd0) begin n_fail++; $display("FAIL reset_hold got=%h exp=0", {sample_l, sample_r}); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL reset_irq got=%b exp=1", irq); end
  endtask

  task automatic test_basic();
    logic [39:0] tbl [4];
    logic [39:0] e;
    tbl[0] = {20'd1, 20'd2}; tbl[1] = {20'd3, 20'd4}; tbl[2] = {20'd5, 20'd6}; tbl[3] = 40'd0;
    enable = 1'b1;
    step(1'b1, {20'd1, 20'd2}, 1'b0, 1'b0);
    step(1'b1, {20'd3, 20'd4}, 1'b0, 1'b0);
    step(1'b1, {20'd5, 20'd6}, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 40'd0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      n_checks++; if ({sample_l, sample_r} !== e) begin n_fail++; $display("FAIL basic_model[%0d] got=%h exp=%h", i, {sample_l, sample_r}, e); end
      n_checks++; if ({sample_l, sample_r} !== tbl[i]) begin n_fail++; $display("FAIL basic_table[%0d] got=%h exp=%h", i, {sample_l, sample_r}, tbl[i]); end
    end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL basic_underrun got=%b exp=1", underrun); end
    n_checks++; if (level !== 6'd0) begin n_fail++; $display("FAIL basic_level got=%0d exp=0", level); end
    underrun_clr = 1'b1; step(1'b0, 40'd0, 1'b0, 1'b0); underrun_clr = 1'b0;
    n_checks++; if (underrun !== m_under) begin n_fail++; $display("FAIL basic_clr got=%b exp=%b", underrun, m_under); end
  endtask

  task automatic test_fill();
    logic [39:0] e;
    enable = 1'b0;
    for (int i = 0; i < DEPTH; i++) step(1'b1, 40'(i + 100), 1'b0, 1'b0);
    n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL fill_wr_ready got=%b exp=0", wr_ready); end
    n_checks++; if (level !== 6'd32) begin n_fail++; $display("FAIL fill_level got=%0d exp=32", level); end
    step(1'b1, 40'hdead, 1'b0, 1'b0);
    n_checks++; if (level !== 6'(mq.size())) begin n_fail++; $display("FAIL fill_refused got=%0d exp=%0d", level, mq.size()); end
    enable = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b0, 40'd0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      n_checks++; if ({sample_l, sample_r} !== e) begin n_fail++; $display("FAIL fill_pop[%0d] got=%h exp=%h", k, {sample_l, sample_r}, e); end
      if (k == 0) begin
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_back got=%b exp=1", wr_ready); end
      end
    end
    step(1'b0, 40'd0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if ({sample_l, sample_r} !== e) begin n_fail++; $display("FAIL fill_no_33rd got=%h exp=%h", {sample_l, sample_r}, e); end
    n_checks++; if (underrun !== m_under) begin n_fail++; $display("FAIL fill_underrun got=%b exp=%b", underrun, m_under); end
    underrun_clr = 1'b1; step(1'b0, 40'd0, 1'b0, 1'b0); underrun_clr = 1'b0;
  endtask

  task automatic test_wrap();
    logic [39:0] e;
    int k;
    k = 0; enable = 1'b1; mute = 1'b0;
    for (int i = 0; i < 103; i++) begin
      step(i < 100, 40'(i), i >= 3, 1'b0);
      if (i >= 3) begin
        e = exp_q.pop_front();
        n_checks++; if ({sample_l, sample_r} !== e || e !== 40'(k)) begin n_fail++; $display("FAIL wrap[%0d] got=%h exp=%h", k, {sample_l, sample_r}, 40'(k)); end
        k++;
      end
      n_checks++; if (level !== 6'(mq.size())) begin n_fail++; $display("FAIL wrap_level[%0d] got=%0d exp=%0d", i, level, mq.size()); end
    end
  endtask

  task automatic test_mute();
    logic [39:0] e;
    enable = 1'b1;
    step(1'b1, {20'd7, 20'd8}, 1'b0, 1'b0);
    step(1'b1, {20'd9, 20'd10}, 1'b0, 1'b0);
    n_checks++; if (level !== 6'd2) begin n_fail++; $display("FAIL mute_level_pre got=%0d exp=2", level); end
    mute = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 40'd0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      n_checks++; if ({sample_l, sample_r} !== e || e !== 40'd0) begin n_fail++; $display("FAIL mute_hold[%0d] got=%h exp=0", i, {sample_l, sample_r}); end
    end
    mute = 1'b0;
    n_checks++; if (level !== 6'd0) begin n_fail++; $display("FAIL mute_level_post got=%0d exp=0", level); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL mute_underrun got=%b exp=0", underrun); end
  endtask

  task automatic test_flush();
    logic [39:0] e;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b1, {20'h11111 + 20'(i), 20'h22222 + 20'(i)}, 1'b0, 1'b0);
    step(1'b0, 40'd0, 1'b1, 1'b0);
    e = exp_q.pop_front();
    n_checks++; if ({sample_l, sample_r} !== e) begin n_fail++; $display("FAIL flush_prefetch got=%h exp=%h", {sample_l, sample_r}, e); end
    n_checks++; if (level !== 6'd4) begin n_fail++; $display("FAIL flush_level_pre got=%0d exp=4", level); end
    step(1'b1, 40'habcde_12345, 1'b1, 1'b1);
    e = exp_q.pop_front();
    n_checks++; if ({sample_l, sample_r} !== e) begin n_fail++; $display("FAIL flush_hold got=%h exp=%h", {sample_l, sample_r}, e); end
    n_checks++; if (level !== 6'd0) begin n_fail++; $display("FAIL flush_level got=%0d exp=0", level); end
    n_checks++; if (underrun !== 1'b0) begin n_fail++; $display("FAIL flush_underrun got=%b exp=0", underrun); end
    n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL flush_wr_ready got=%b exp=1", wr_ready); end
    underrun_clr = 1'b1; step(1'b0, 40'd0, 1'b1, 1'b0); underrun_clr = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if ({sample_l, sample_r} !== e) begin n_fail++; $display("FAIL flush_empty_hold got=%h exp=%h", {sample_l, sample_r}, e); end
    n_checks++; if (underrun !== 1'b1) begin n_fail++; $display("FAIL set_beats_clr got=%b exp=1", underrun); end
    underrun_clr = 1'b1; step(1'b0, 40'd0, 1'b0, 1'b0); underrun_clr = 1'b0;
    n_checks++; if (underrun !== m_under) begin n_fail++; $display("FAIL flush_clr got=%b exp=%b", underrun, m_under); end
  endtask

  task automatic test_irq();
    logic [39:0] e;
    thresh = 6'd2; enable = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 40'(i + 50), 1'b0, 1'b0);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_above got=%b exp=0", irq); end
    step(1'b0, 40'd0, 1'b1, 1'b0);
    void'(exp_q.pop_front());
    n_checks++; if (level !== 6'd2 || irq !== 1'b1) begin n_fail++; $display("FAIL irq_rise got=%b/%0d exp=1/2", irq, level); end
    enable = 1'b0; #1;
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_disabled got=%b exp=0", irq); end
    enable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 40'd0, 1'b1, 1'b0);
      e = exp_q.pop_front();
      n_checks++; if ({sample_l, sample_r} !== e) begin n_fail++; $display("FAIL irq_drain[%0d] got=%h exp=%h", i, {sample_l, sample_r}, e); end
    end
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; enable = 1'b0; mute = 1'b0;
    flush = 1'b0; thresh = '0; next = 1'b0; underrun_clr = 1'b0; m_under = 1'b0;
    test_reset();
    test_basic();
    test_fill();
    test_wrap();
    test_mute();
    test_flush();
    test_irq();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dac_feeder.md
Name: dac_feeder

Overview:
- Stereo sample scheduler sitting between the bus-side audio register interface and the 20-bit I2S DAC control circuit.
- Buffers stereo sample pairs in a FIFO and presents the next pair on sample_l/sample_r.
- Pops one pair per DAC `next` pulse; on FIFO starvation it substitutes silence and flags an underrun.
- Provides mute, enable, flush and a fill-level low-water interrupt for the CPU driver.

Parameters:
- DEPTH_LOG2, 5, log2 of FIFO depth in stereo pairs (default 32 entries).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- wr_valid  input  1  producer offers a sample pair.
- wr_data  input  40  [39:20] left sample, [19:0] right sample, two's complement.
- wr_ready  output  1  FIFO can accept; transfer when wr_valid & wr_ready at a rising edge.
- enable  input  1  level; 1 = consume samples on next.
- mute  input  1  level; 1 = output zeros but keep consuming.
- flush  input  1  single-cycle pulse; empties FIFO.
- thresh  input  DEPTH_LOG2+1  low-water mark for irq.
- next  input  1  one-cycle pulse from the DAC; DAC loads sample_l/sample_r at this edge.
- sample_l  output  20  held left sample to the DAC.
- sample_r  output  20  held right sample to the DAC.
- level  output  DEPTH_LOG2+1  current FIFO occupancy, 0..2^DEPTH_LOG2.
- underrun  output  1  sticky starvation flag.
- underrun_clr  input  1  single-cycle pulse; clears underrun.
- irq  output  1  level-sensitive interrupt request.

Behaviour:
Reset:
- Read/write pointers 0, level 0, sample_l/sample_r 0, underrun 0.
- wr_ready 1 in the first cycle after reset; irq = enable at that point (level 0 <= any thresh).

FIFO:
- Circular buffer of 2^DEPTH_LOG2 entries × 40 bits; pointers wrap modulo depth.
- level is a registered count.
- wr_ready = (level != 2^DEPTH_LOG2); a write offered while full is not accepted and is not stored.
- Push and pop in the same cycle leave level unchanged.
- A push while full with a simultaneous pop is still refused, because wr_ready reflects the registered level.

Pop / holding registers:
- sample_l/sample_r update only on a cycle where next = 1. The DAC captures the old values at that edge, so the held pair is always one sample ahead; latency from FIFO head to DAC is one frame.
- On next with enable = 1 and level > 0: pop the head entry; hold <= mute ? 0 : entry.
- On next with enable = 1 and level = 0: hold <= 0, underrun <= 1, no pop.
- A write arriving in the same cycle is not bypassed, so underrun is still set.
- On next with enable = 0: hold <= 0, no pop, no underrun. Writes are still accepted, which allows prefill before enabling.
- Cycles without next: hold is unchanged.

Flush:
- Pointers and level <= 0.
- Has priority over any push or pop in the same cycle; a concurrent write is dropped, with wr_ready still 1.
- If next coincides with flush, hold <= 0 and no underrun is set.
- sample_l/sample_r are otherwise unaffected.

Underrun:
- Set condition as above; cleared by underrun_clr.
- Set wins over a simultaneous clear.

irq:
- irq = enable & (level <= thresh), combinational from registered state.
- thresh >= depth makes irq continuously asserted while enabled.

Test Plan:
- Reset, then write 3 pairs ({L=1,R=2},{3,4},{5,6}), enable=1, pulse next 4 times: hold sequence {1,2},{3,4},{5,6},{0,0}; underrun=1 after the 4th next; level ends 0.
- Fill with DEPTH_LOG2=5: write 33 pairs back-to-back → wr_ready=0 after the 32nd, level=32, the 33rd is not stored; one next pops and wr_ready returns to 1 the following cycle.
- Wrap-around: write/pop 100 pairs with data = index, keeping level between 1 and 5 → every popped value equals its index, in order.
- Mute=1 with 2 pairs queued, 2 next pulses → hold {0,0} both times, level 2→0, underrun stays 0.
- Flush coinciding with wr_valid and next while level=4 → level=0, hold {0,0}, underrun 0, written pair absent; underrun_clr coinciding with an underrun set → underrun stays 1.
- thresh=2, enable=1: level 3→2 via next → irq rises in the same cycle level becomes 2; enable=0 → irq 0.
